// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: checks a VGA sync/blank stream against expected timing and reports pixel coordinates once locked
//   clk, rst          system clock and asynchronous active-low reset
//   vga_clk           pixel clock, sampled as data; its rising edge is one tick
//   hsync, vsync      sync inputs, asserted level SYNC_POL
//   blank_n           1 marks an active pixel
//   err_clr           clears the sticky timing_err
//   x_pos, y_pos      coordinate of the current active pixel
//   pixel_valid       one-clk pulse per active pixel while locked
//   locked            timing verified over a full frame
//   timing_err        sticky, set when a locked stream breaks timing
//   line_len          last measured line length in ticks
//   frame_cnt         frames passed while locked (wraps)
module vga_timing_monitor #(
  parameter int   H_TOTAL  = 800,
  parameter int   H_ACTIVE = 640,
  parameter int   V_TOTAL  = 525,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_clk,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_n,
  input  logic       err_clr,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pixel_valid,
  output logic       locked,
  output logic       timing_err,
  output logic [9:0] line_len,
  output logic [7:0] frame_cnt
);
  localparam logic [9:0] HT = 10'(H_TOTAL);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t     state_q;
  logic       vga_q, hs_q, vs_q, seen_h_q, bad_q, lock_q, err_q;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d, len_q, len_d;
  logic [7:0] fc_q;
  logic       tick, hs_edge, vs_edge, line_fail, frame_ok;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return &v ? v : v + 10'd1;
  endfunction

  // x_q at an hsync edge holds the active-pixel count of the line just ended
  always_comb begin
    tick      = vga_clk & ~vga_q;
    hs_edge   = tick & (hs_q != SYNC_POL) & (hsync == SYNC_POL);
    vs_edge   = tick & (vs_q != SYNC_POL) & (vsync == SYNC_POL);
    line_fail = hs_edge & seen_h_q & ((h_cnt_q != HT) | ((x_q != '0) & (x_q != HA)));
    frame_ok  = v_cnt_q == VT;
    h_cnt_d   = hs_edge ? 10'd1 : tick ? sat_inc(h_cnt_q) : h_cnt_q;
    len_d     = hs_edge ? h_cnt_q : len_q;
    v_cnt_d   = vs_edge ? {9'd0, hs_edge} : hs_edge ? sat_inc(v_cnt_q) : v_cnt_q;
    x_d       = hs_edge ? '0 : (tick & blank_n) ? sat_inc(x_q) : x_q;
    y_d       = vs_edge ? '0 : (hs_edge & (x_q != '0)) ? sat_inc(y_q) : y_q;
  end

  assign pixel_valid = tick & blank_n & lock_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign locked      = lock_q;
  assign timing_err  = err_q;
  assign line_len    = len_q;
  assign frame_cnt   = fc_q;

  // sync samples reset to the inactive level so the first asserted sample is an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      vga_q    <= 1'b0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      seen_h_q <= 1'b0;
      bad_q    <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      len_q    <= '0;
      fc_q     <= '0;
    end else begin
      vga_q   <= vga_clk;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      len_q   <= len_d;
      if (err_clr) err_q <= 1'b0;
      if (tick) begin
        hs_q <= hsync;
        vs_q <= vsync;
        if (hs_edge) seen_h_q <= 1'b1;
        case (state_q)
          IDLE: if (vs_edge) begin
            state_q <= MEASURE;
            bad_q   <= 1'b0;
          end
          MEASURE: if (vs_edge) begin
            bad_q <= 1'b0;
            if (frame_ok & ~bad_q & ~line_fail) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
            end
          end else if (line_fail) bad_q <= 1'b1;
          LOCKED: if (line_fail | (vs_edge & ~frame_ok)) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (vs_edge) fc_q <= fc_q + 8'd1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed frame-level vectors plus stall, reset and clear corner cases on a 20x10 timing
module tb_vga_timing_monitor;
  localparam int HT = 20, HA = 12, VT = 10;
  logic clk = 0, rst = 0, vga_clk = 0, hsync = 1, vsync = 1, blank_n = 0, err_clr = 0;
  logic [9:0] x_pos, y_pos, line_len;
  logic [7:0] frame_cnt;
  logic pixel_valid, locked, timing_err;
  int n_chk = 0, n_err = 0;
  int pv_cnt = 0, mark = 0, fx = 0, fy = 0, lx = 0, ly = 0;

  vga_timing_monitor #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst(rst), .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .err_clr(err_clr), .x_pos(x_pos), .y_pos(y_pos),
    .pixel_valid(pixel_valid), .locked(locked), .timing_err(timing_err),
    .line_len(line_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (pv_cnt == mark) begin
        fx = int'(x_pos);
        fy = int'(y_pos);
      end
      lx = int'(x_pos);
      ly = int'(y_pos);
      pv_cnt++;
    end
  end

  typedef struct {
    int nl; int bl; int blen; bit clr;
    bit lk; bit er; int len; int fc; int px;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tk(input bit hs, input bit vs, input bit bl);
    @(posedge clk); #1;
    hsync = hs; vsync = vs; blank_n = bl; vga_clk = 1;
    @(posedge clk); #1;
    vga_clk = 0;
  endtask

  task automatic line(input bit vsl, input bit act, input int len, input int t0, input int t1);
    for (int t = t0; t < t1; t++) tk(t >= 2, !vsl, act && t >= 4 && t < 4 + HA);
    if (t1 > len) $display("line overrun");
  endtask

  task automatic frame(input int nl, input int bl, input int blen);
    for (int l = 0; l < nl; l++) line(l < 2, l >= 3 && l < 9, (l == bl) ? blen : HT, 0, (l == bl) ? blen : HT);
  endtask

  task automatic outs(input string tag, input bit lk, input bit er, input int len, input int fc);
    @(negedge clk);
    chk({tag, " locked"}, int'(locked), int'(lk));
    chk({tag, " timing_err"}, int'(timing_err), int'(er));
    chk({tag, " line_len"}, int'(line_len), len);
    chk({tag, " frame_cnt"}, int'(frame_cnt), fc);
  endtask

  initial begin
    vec_t v[12];
    int mk;
    v[0]  = '{10, -1, 20, 0, 0, 0, 20, 0, 0};
    v[1]  = '{10, -1, 20, 0, 1, 0, 20, 0, 72};
    v[2]  = '{10, -1, 20, 0, 1, 0, 20, 1, 72};
    v[3]  = '{10,  8, 21, 0, 0, 1, 21, 2, 72};
    v[4]  = '{10, -1, 20, 0, 0, 1, 20, 2, 0};
    v[5]  = '{10, -1, 20, 0, 1, 1, 20, 2, 72};
    v[6]  = '{10, -1, 20, 1, 1, 0, 20, 3, 72};
    v[7]  = '{10,  2, 19, 0, 0, 1, 20, 4, 0};
    v[8]  = '{11, -1, 20, 0, 0, 1, 20, 4, 0};
    v[9]  = '{10, -1, 20, 0, 0, 1, 20, 4, 0};
    v[10] = '{10, -1, 20, 0, 1, 1, 20, 4, 72};
    v[11] = '{10, -1, 20, 0, 1, 1, 20, 5, 72};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst x_pos", int'(x_pos), 0);
    chk("rst y_pos", int'(y_pos), 0);
    chk("rst pixel_valid", int'(pixel_valid), 0);
    outs("rst", 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1;
    for (int i = 0; i < 12; i++) begin
      if (v[i].clr) begin
        @(posedge clk); #1 err_clr = 1;
        @(posedge clk); #1 err_clr = 0;
      end
      mark = pv_cnt;
      frame(v[i].nl, v[i].bl, v[i].blen);
      outs($sformatf("vec%0d", i), v[i].lk, v[i].er, v[i].len, v[i].fc);
      chk($sformatf("vec%0d pulses", i), pv_cnt - mark, v[i].px);
      if (v[i].px == 72) begin
        chk($sformatf("vec%0d first x", i), fx, 0);
        chk($sformatf("vec%0d first y", i), fy, 0);
        chk($sformatf("vec%0d last x", i), lx, HA - 1);
        chk($sformatf("vec%0d last y", i), ly, 5);
      end
    end
    for (int l = 0; l < 4; l++) line(l < 2, l >= 3, HT, 0, HT);
    line(0, 1, HT, 0, 10);
    @(negedge clk);
    chk("pre-stall x_pos", int'(x_pos), 6);
    chk("pre-stall y_pos", int'(y_pos), 1);
    mk = pv_cnt;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("stall x_pos", int'(x_pos), 6);
    chk("stall frame_cnt", int'(frame_cnt), 6);
    chk("stall pulses", pv_cnt - mk, 0);
    chk("stall locked", int'(locked), 1);
    line(0, 1, HT, 10, HT);
    for (int l = 5; l < 10; l++) line(0, l < 9, HT, 0, HT);
    frame(10, -1, HT);
    outs("post-stall", 1, 1, 20, 7);
    for (int l = 0; l < 4; l++) line(l < 2, l >= 3, HT, 0, HT);
    line(0, 1, HT, 0, 10);
    #1 rst = 0;
    #1;
    chk("async rst x_pos", int'(x_pos), 0);
    chk("async rst y_pos", int'(y_pos), 0);
    chk("async rst pixel_valid", int'(pixel_valid), 0);
    chk("async rst locked", int'(locked), 0);
    chk("async rst timing_err", int'(timing_err), 0);
    chk("async rst line_len", int'(line_len), 0);
    chk("async rst frame_cnt", int'(frame_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    line(0, 1, HT, 10, HT);
    for (int l = 5; l < 10; l++) line(0, l < 9, HT, 0, HT);
    frame(10, -1, HT);
    outs("relock1", 0, 0, 20, 0);
    frame(10, -1, HT);
    outs("relock2", 1, 0, 20, 0);
    line(1, 0, HT, 0, HT);
    line(1, 0, HT, 0, HT);
    line(0, 0, 19, 0, 19);
    @(posedge clk); #1;
    err_clr = 1; hsync = 0; vsync = 1; blank_n = 0; vga_clk = 1;
    @(posedge clk); #1;
    err_clr = 0; vga_clk = 0;
    line(0, 1, HT, 1, HT);
    for (int l = 4; l < 10; l++) line(0, l < 9, HT, 0, HT);
    @(negedge clk);
    chk("set+clr timing_err", int'(timing_err), 1);
    chk("set+clr locked", int'(locked), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
